// File: rtl/pwm_w_int_pkg.sv
// rtl/pwm_w_int_pkg.sv - shared types and constants for the PWM_w_int timing core
//
// Purpose: state encoding, register map offsets, CTRL bit positions and
// default widths used by the PWM core, its interface and its sub-modules.
// Ports: none (package).

package pwm_w_int_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Register map as seen by the AXI4-Lite slave that feeds this core
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_PERIOD = 4'h4;
  localparam logic [3:0] REG_DUTY0  = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_PRESC_W = 16;

endpackage

// File: rtl/pwm_w_int_if.sv
// rtl/pwm_w_int_if.sv - config/status bundle between register slave and PWM core
//
// Purpose: groups the decoded register values, strobes and the core's
// outputs into one bundle.
// Modports:
//   master - register slave side: drives cfg_*, cfg_wr_strobe, irq_clr;
//            reads pwm_out, irq, irq_status, cnt_value.
//   slave  - PWM core side: the reverse.

interface pwm_w_int_if
  import pwm_w_int_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) ();

  logic                    cfg_enable;
  logic                    cfg_irq_en;
  logic [CNT_W-1:0]        cfg_period;
  logic [NUM_CH*CNT_W-1:0] cfg_duty;
  logic [PRESC_W-1:0]      cfg_presc;
  logic                    cfg_wr_strobe;
  logic                    irq_clr;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    irq;
  logic                    irq_status;
  logic [CNT_W-1:0]        cnt_value;

  modport master (
    output cfg_enable, cfg_irq_en, cfg_period, cfg_duty, cfg_presc,
           cfg_wr_strobe, irq_clr,
    input  pwm_out, irq, irq_status, cnt_value
  );

  modport slave (
    input  cfg_enable, cfg_irq_en, cfg_period, cfg_duty, cfg_presc,
           cfg_wr_strobe, irq_clr,
    output pwm_out, irq, irq_status, cnt_value
  );

endinterface

// File: rtl/pwm_w_int_prescaler.sv
// rtl/pwm_w_int_prescaler.sv - divide-by-(presc+1) tick generator
//
// Purpose: emits a one-cycle tick every presc_i+1 clock cycles while not
// cleared; only instantiated when PWM_W_INT_PRESCALER_EN is defined.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   clr_i   - hold count at zero and suppress tick
//   presc_i - divide value (tick period minus one)
//   tick_o  - combinational tick, high on the last cycle of each division

module pwm_w_int_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               at_end;

  assign at_end = (presc_cnt_q == presc_i);
  assign tick_o = !clr_i && at_end;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (clr_i || at_end) begin
      presc_cnt_d = '0;
    end else begin
      presc_cnt_d = presc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_w_int_core.sv
// rtl/pwm_w_int_core.sv - PWM period/duty engine with shadowed config and period-done irq
//
// Purpose: one shared period counter drives NUM_CH compare outputs. Period,
// duty and prescaler are held in active registers that reload from cfg_*
// only on start or at a period boundary after a config write, so a running
// period is never disturbed. Boundary sets a sticky status and a gated
// level interrupt.
// Build option: PWM_W_INT_PRESCALER_EN - when defined, the counter advances
// every cfg_presc+1 ACLK cycles; otherwise it advances every cycle and
// cfg_presc is ignored.
// Ports:
//   ACLK    - clock
//   ARESETN - asynchronous active-low reset
//   bus     - pwm_w_int_if.slave: cfg_enable, cfg_irq_en, cfg_period,
//             cfg_duty, cfg_presc, cfg_wr_strobe, irq_clr in;
//             pwm_out, irq, irq_status, cnt_value out

module pwm_w_int_core
  import pwm_w_int_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  pwm_w_int_if.slave   bus
);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [CNT_W-1:0]              period_q, period_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  duty_q, duty_d;
  logic                          upd_pend_q, upd_pend_d;
  logic [NUM_CH-1:0]             pwm_q, pwm_d;
  logic                          irq_status_q, irq_status_d;
  logic                          irq_q, irq_d;

  logic                          run_now;
  logic                          tick;
  logic                          boundary;
  logic                          load;

  // Counting only proceeds while running and still enabled; dropping enable
  // forces outputs low on the very cycle the FSM lands in IDLE.
  assign run_now = (state_q == RUN) && bus.cfg_enable;

`ifdef PWM_W_INT_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = bus.cfg_presc;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  pwm_w_int_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .clr_i   (!run_now),
    .presc_i (presc_q),
    .tick_o  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    duty_d       = duty_q;
    upd_pend_d   = upd_pend_q;
    irq_status_d = irq_status_q;
    irq_d        = irq_status_q && bus.cfg_irq_en;
    pwm_d        = '0;
    boundary     = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.cfg_enable) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.cfg_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == period_q) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (bus.cfg_wr_strobe) begin
      upd_pend_d = 1'b1;
    end

    // A strobe landing on the boundary cycle already presents the new values
    // on cfg_*, so it takes effect at this boundary rather than the next one.
    if (boundary && (upd_pend_q || bus.cfg_wr_strobe)) begin
      load = 1'b1;
    end

    if (load) begin
      period_d   = bus.cfg_period;
      duty_d     = bus.cfg_duty;
      upd_pend_d = 1'b0;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = run_now && (cnt_q < duty_q[i]);
    end

    // Set beats clear when both land in the same cycle.
    if (boundary) begin
      irq_status_d = 1'b1;
    end else if (bus.irq_clr) begin
      irq_status_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      duty_q       <= '0;
      upd_pend_q   <= 1'b0;
      pwm_q        <= '0;
      irq_status_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      upd_pend_q   <= upd_pend_d;
      pwm_q        <= pwm_d;
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.irq        = irq_q;
  assign bus.irq_status = irq_status_q;
  assign bus.cnt_value  = cnt_q;

endmodule
